ft_fifo_rr_arb: RTL and testbench

Round-robin scheduler that shares one downstream consumer among NUM_REQ flow-through FIFO outputs (valid/data/pop style, zero-latency pop-to-next-data). It selects one requester, drains it beat-by-beat into a single registered output stage with ready/valid backpressure, and holds the grant until end-of-packet or a per-grant beat cap. It sits between per-source flow-through FIFOs and a shared datapath such as a RAM write port or a PCIe/AXI master.

---
 rtl/ft_fifo_rr_arb.sv | 133 +++++++++++++
 tb/tb_ft_fifo_rr_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_fifo_rr_arb.sv
// ft_fifo_rr_arb
// Round-robin scheduler that shares one downstream consumer among NUM_REQ
// flow-through FIFO heads. A requester is granted from IDLE, drained
// beat-by-beat into a registered output stage, and released at
// end-of-packet or after MAX_BURST pops. Each release costs one IDLE cycle.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   sync_rst_n       synchronous active-low clear (same effect as rst)
//   req_valid[i]     FIFO i head valid
//   req_data         FIFO i head data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last[i]      FIFO i head beat is end-of-packet
//   req_pop[i]       pop strobe to FIFO i (one-hot or zero, combinational)
//   out_valid/out_data/out_last/out_src   registered output beat
//   out_ready        consumer accepts when out_valid && out_ready
//   busy             a grant is active
module ft_fifo_rr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sync_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_pop,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [$clog2(NUM_REQ)-1:0]    out_src,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      cand;
  logic                  found;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  pop;
  logic                  release_gnt;
  logic                  in_reset;
  logic [DATA_WIDTH-1:0] gnt_data;

  assign in_reset = rst | ~sync_rst_n;
  assign busy     = (state == GRANT);
  assign gnt_data = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Search upward from rr_ptr+1 with wrap. The loop runs from the farthest
  // offset down to the nearest so the nearest valid requester is written last.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Pop is combinational from the granted head; it is suppressed while any
  // reset is active so a FIFO never loses a beat the register will discard.
  always_comb begin
    pop         = (state == GRANT) && req_valid[gnt_idx] &&
                  (!out_valid || out_ready) && !in_reset;
    release_gnt = pop && (req_last[gnt_idx] || (beat_cnt == CAP));
    req_pop     = '0;
    if (pop) req_pop[gnt_idx] = 1'b1;
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   if (release_gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      gnt_idx   <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (!sync_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      gnt_idx   <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        gnt_idx  <= winner;
        beat_cnt <= '0;
      end
      if (pop) beat_cnt <= beat_cnt + 1'b1;
      // rr_ptr only moves on release, so a split packet's source drops to
      // lowest priority behind everyone else that is waiting.
      if (release_gnt) rr_ptr <= gnt_idx;
      // A reload takes priority over the accept-clear, keeping out_valid
      // high when the old beat leaves on the same edge a new one arrives.
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_last  <= req_last[gnt_idx];
        out_src   <= gnt_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ft_fifo_rr_arb.sv
`timescale 1ns/1ps
module tb_ft_fifo_rr_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           sync_rst_n;
  logic           out_ready;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_pop;
  logic [N*W-1:0] req_data;
  logic           out_valid;
  logic           out_last;
  logic           busy;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;

  always #5 clk = ~clk;

  ft_fifo_rr_arb #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .sync_rst_n(sync_rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_pop(req_pop), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_src(out_src), .out_ready(out_ready),
    .busy(busy)
  );

  typedef struct {logic [W-1:0] d; bit l;} beat_t;
  typedef struct {int src; logic [W-1:0] d; bit l; int t;} rx_t;

  beat_t fq [N][$];   // source FIFOs; head is what the DUT sees
  rx_t   rx [$];      // beats accepted by the consumer, taken from the DUT

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit cmp_en = 0;

  // Reference scheduler: who owns the output, who was served last, how many
  // beats the current owner has had, and what the output register holds.
  int           owner;
  int           last_owner;
  int           beats;
  bit           m_valid;
  bit           m_last;
  logic [W-1:0] m_data;
  int           m_src;
  logic [N-1:0] ep;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; last_owner = N - 1; beats = 0;
    m_valid = 0; m_last = 0; m_data = '0; m_src = 0;
  endtask

  function automatic bit model_pop();
    if (rst || !sync_rst_n || owner < 0) return 1'b0;
    return (fq[owner].size() > 0) && (!m_valid || out_ready);
  endfunction

  task automatic model_step();
    bit    p;
    int    s;
    beat_t b;
    rx_t   r;
    if (rst || !sync_rst_n) begin
      model_reset();
      return;
    end
    if (out_valid && out_ready) begin
      r.src = int'(out_src); r.d = out_data; r.l = out_last; r.t = cyc_n;
      rx.push_back(r);
    end
    p = model_pop();
    if (m_valid && out_ready) m_valid = 0;
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        s = (last_owner + k) % N;
        if (fq[s].size() > 0) begin
          owner = s; beats = 0;
          break;
        end
      end
    end else if (p) begin
      b = fq[owner].pop_front();
      m_valid = 1; m_data = b.d; m_last = b.l; m_src = owner;
      beats++;
      if (b.l || beats == MB) begin
        last_owner = owner;
        owner = -1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    model_step();
    cyc_n++;
  end

  // Cycle-by-cycle comparison against the reference scheduler.
  always @(negedge clk) begin
    if (cmp_en) begin
      ep = '0;
      if (model_pop()) ep[owner] = 1'b1;
      chk("cyc_req_pop", req_pop, ep);
      chk("cyc_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("cyc_out_data", out_data, m_data);
        chk("cyc_out_last", out_last, m_last);
        chk("cyc_out_src", out_src, m_src);
      end
      chk("cyc_busy", busy, owner >= 0);
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = fq[i].size() > 0;
      req_data[i*W +: W] = '0;
      req_last[i] = 1'b0;
      if (fq[i].size() > 0) begin
        req_data[i*W +: W] = fq[i][0].d;
        req_last[i] = fq[i][0].l;
      end
    end
  endtask

  task automatic push(int src, logic [W-1:0] d, bit l);
    beat_t b;
    b.d = d; b.l = l;
    fq[src].push_back(b);
    drive();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_rx(int n, string name);
    for (int t = 0; t < 300 && rx.size() < n; t++) cyc();
    chk(name, rx.size(), n);
  endtask

  int exp_src [11] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1};
  logic [W-1:0] ed;

  initial begin
    rst = 1; sync_rst_n = 1; out_ready = 1;
    req_valid = '0; req_data = '0; req_last = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_pop", req_pop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    rst = 0;
    cmp_en = 1;

    // Single source, three-beat packet, consumer always ready.
    rx.delete();
    push(0, 32'hA0, 0); push(0, 32'hB0, 0); push(0, 32'hC0, 1);
    cyc();
    chk("t1_pop_c1", req_pop, 4'b0001);
    chk("t1_valid_c1", out_valid, 0);
    cyc();
    chk("t1_data_c2", out_data, 32'hA0);
    chk("t1_pop_c2", req_pop, 4'b0001);
    cyc();
    chk("t1_data_c3", out_data, 32'hB0);
    chk("t1_pop_c3", req_pop, 4'b0001);
    cyc();
    chk("t1_data_c4", out_data, 32'hC0);
    chk("t1_last_c4", out_last, 1);
    chk("t1_busy_c4", busy, 0);
    chk("t1_pop_c4", req_pop, 4'b0000);
    wait_rx(3, "t1_count");
    chk("t1_last0", rx[0].l, 0);
    chk("t1_last2", rx[2].l, 1);

    // Sync clear restores requester 0 priority; then single-beat packets
    // from all four sources rotate 0,1,2,3 at one beat per two clocks.
    sync_rst_n = 0;
    cyc();
    sync_rst_n = 1;
    rx.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) push(i, 32'h100 + 32'h10 * i + j, 1);
    wait_rx(8, "t2_count");
    for (int k = 0; k < 8; k++) begin
      chk("t2_src", rx[k].src, k % 4);
      chk("t2_data", rx[k].d, 32'h100 + 32'h10 * (k % 4) + (k / 4));
      if (k > 0) chk("t2_gap", rx[k].t - rx[k-1].t, 2);
    end

    // Ten-beat packet on 1 is split at the 4-beat cap around 2's packet,
    // with a five-cycle consumer stall mid-burst.
    rx.delete();
    for (int k = 0; k < 10; k++) push(1, 32'h200 + k, k == 9);
    push(2, 32'h300, 1);
    repeat (4) cyc();
    out_ready = 0;
    chk("t4_snap", out_data, 32'h202);
    repeat (5) begin
      cyc();
      chk("t4_hold_data", out_data, 32'h202);
      chk("t4_hold_pop", req_pop, 0);
      chk("t4_hold_valid", out_valid, 1);
    end
    out_ready = 1;
    wait_rx(11, "t3_count");
    for (int k = 0; k < 11; k++) begin
      ed = (k < 4) ? 32'h200 + k : (k == 4) ? 32'h300 : 32'h200 + k - 1;
      chk("t3_src", rx[k].src, exp_src[k]);
      chk("t3_data", rx[k].d, ed);
      chk("t3_last", rx[k].l, (k == 4) || (k == 10));
    end

    // Asynchronous reset while source 2 is granted mid-burst.
    rx.delete();
    push(2, 32'h400, 0); push(2, 32'h401, 0); push(2, 32'h402, 1);
    cyc();
    cyc();
    #1 rst = 1;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_pop", req_pop, 0);
    push(0, 32'h500, 1);
    @(posedge clk);
    #1;
    rst = 0;
    drive();
    wait_rx(3, "t5_count");
    chk("t5_first_src", rx[0].src, 0);
    chk("t5_first_data", rx[0].d, 32'h500);
    chk("t5_resume_data", rx[1].d, 32'h401);
    chk("t5_resume_last", rx[2].l, 1);

    // One-cycle synchronous clear during a grant with a beat held.
    rx.delete();
    push(3, 32'h600, 0); push(3, 32'h601, 0); push(3, 32'h602, 1);
    cyc();
    cyc();
    sync_rst_n = 0;
    #1;
    chk("t6_pop_in_clear", req_pop, 0);
    chk("t6_valid_before", out_valid, 1);
    @(posedge clk);
    #1;
    sync_rst_n = 1;
    drive();
    chk("t6_valid_after", out_valid, 0);
    chk("t6_busy_after", busy, 0);
    wait_rx(2, "t6_count");
    chk("t6_data0", rx[0].d, 32'h601);
    chk("t6_data1", rx[1].d, 32'h602);
    chk("t6_src1", rx[1].src, 3);

    repeat (3) cyc();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
